dmem_responder: RTL

- Multi-cycle data-memory target that answers load/store requests from the core's load/store path.
- Handles byte-lane writes (byte enables come from the store extractor), alignment/range checking, programmable wait states and response backpressure.
- Sits between the core datapath and a word-organised register-array RAM.
- Serves one outstanding request at a time: no pipelining.

---
 rtl/dmem_if.sv | 24 ++
 rtl/dmem_responder.sv | 128 ++++++++++++
 2 files changed

// File: rtl/dmem_if.sv
// Request/response bus between the core load/store path (master) and
// a data-memory target (slave). One outstanding request at a time.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory target: accepts one load/store, waits a fixed
// number of cycles, performs the RAM access with byte lanes and
// alignment/range checking, then holds the response until taken.
module dmem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_CYCLES = 2
) (
  input logic   clk,
  input logic   reset,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [3:0]  be_reg;
  logic [31:0] rdata_reg;
  logic        err_reg;
  logic        do_access;

  logic [31:0] mem [DEPTH_WORDS];

  // Access operands: with no wait states the access happens on the
  // acceptance edge itself, so the live request is used; otherwise the
  // latched copy is used.
  logic          acc_we;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic [3:0]    acc_be;
  logic [AW-1:0] acc_index;
  logic          acc_err;

  assign acc_we    = (state_reg == IDLE) ? bus.req_we    : we_reg;
  assign acc_addr  = (state_reg == IDLE) ? bus.req_addr  : addr_reg;
  assign acc_wdata = (state_reg == IDLE) ? bus.req_wdata : wdata_reg;
  assign acc_be    = (state_reg == IDLE) ? bus.req_be    : be_reg;
  assign acc_index = acc_addr[AW+1:2];
  assign acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr[31:AW+2] != '0);

  assign bus.req_ready = (state_reg == IDLE);
  assign bus.rsp_valid = (state_reg == RESP);
  assign bus.rsp_rdata = rdata_reg;
  assign bus.rsp_err   = err_reg;

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Next-state logic; also decides on which edge the RAM access happens.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    do_access  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid) begin
          if (WAIT_CYCLES == 0) begin
            state_next = RESP;
            do_access  = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = 4'(WAIT_CYCLES);
          end
        end
      end
      WAIT: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1) begin
          state_next = RESP;
          do_access  = 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request at acceptance; later changes on the bus are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      be_reg    <= '0;
    end else if (state_reg == IDLE && bus.req_valid) begin
      we_reg    <= bus.req_we;
      addr_reg  <= bus.req_addr;
      wdata_reg <= bus.req_wdata;
      be_reg    <= bus.req_be;
    end
  end

  // RAM array: cleared on reset, byte-lane writes for valid stores.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH_WORDS; i++) mem[i] <= '0;
    end else if (do_access && acc_we && !acc_err) begin
      for (int l = 0; l < 4; l++) begin
        if (acc_be[l]) mem[acc_index][8*l +: 8] <= acc_wdata[8*l +: 8];
      end
    end
  end

  // Response data/error registered at the access edge, held until next access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_reg <= '0;
      err_reg   <= 1'b0;
    end else if (do_access) begin
      err_reg   <= acc_err;
      rdata_reg <= (!acc_we && !acc_err) ? mem[acc_index] : 32'h0;
    end
  end
endmodule
